// File: rtl/escalonador_rr.sv
// escalonador_rr: round-robin program scheduler with quantum timer.
// Sequences PC save/restore on the data RAM during context switches.
module escalonador_rr #(
    parameter int NUM_PROGRAMS = 4,
    parameter int QUANTUM      = 16,
    parameter int DATA_WIDTH   = 32,
    localparam int SW = (NUM_PROGRAMS > 1) ? $clog2(NUM_PROGRAMS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start_program,
    input  logic [SW-1:0]           start_slot,
    input  logic                    end_program,
    input  logic                    cpu_stall,
    input  logic [DATA_WIDTH-1:0]   pc_atual,
    input  logic [DATA_WIDTH-1:0]   ram_q,
    output logic                    spc,
    output logic [DATA_WIDTH-1:0]   enderecoSpc,
    output logic                    lpc,
    output logic [SW-1:0]           programa,
    output logic                    pc_load_en,
    output logic [DATA_WIDTH-1:0]   pc_load_value,
    output logic                    cpu_hold,
    output logic [NUM_PROGRAMS-1:0] active_mask,
    output logic                    idle
);

    localparam int CW = $clog2(QUANTUM + 1);
    localparam logic [CW-1:0] QUANTUM_LOAD = CW'(QUANTUM);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SAVE,
        S_SELECT,
        S_LOAD,
        S_LOAD_WAIT,
        S_START_FRESH
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_PROGRAMS-1:0] fresh_mask;
    logic [NUM_PROGRAMS-1:0] active_next;
    logic [NUM_PROGRAMS-1:0] fresh_next;
    logic [NUM_PROGRAMS-1:0] others_mask;
    logic [CW-1:0]           quantum_cnt;
    logic                    others_active;
    logic                    slice_done;
    logic                    sel_found;
    logic [SW-1:0]           sel_slot;
    logic [SW-1:0]           sel_idx;
    logic                    start_ok;

    assign idle     = (active_mask == '0);
    assign cpu_hold = (state != S_RUN);

    // slots other than the running one that could take the CPU
    always_comb begin
        others_mask           = active_mask;
        others_mask[programa] = 1'b0;
        others_active         = |others_mask;
        slice_done            = (quantum_cnt == CNT_ONE) && !cpu_stall;
    end

    // round-robin search starting after programa, programa itself last
    always_comb begin
        sel_found = 1'b0;
        sel_slot  = programa;
        sel_idx   = '0;
        for (int i = NUM_PROGRAMS; i >= 1; i--) begin
            sel_idx = SW'((int'(programa) + i) % NUM_PROGRAMS);
            if (active_mask[sel_idx]) begin
                sel_found = 1'b1;
                sel_slot  = sel_idx;
            end
        end
    end

    // next-state logic of the context-switch sequencer
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (active_mask != '0) begin
                    state_next = S_SELECT;
                end
            end
            S_RUN: begin
                if (end_program) begin
                    state_next = S_SELECT;
                end else if (slice_done && others_active) begin
                    state_next = S_SAVE;
                end
            end
            S_SAVE: begin
                state_next = S_SELECT;
            end
            S_SELECT: begin
                if (!sel_found) begin
                    state_next = S_IDLE;
                end else if (fresh_mask[sel_slot]) begin
                    state_next = S_START_FRESH;
                end else begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                state_next = S_RUN;
            end
            S_START_FRESH: begin
                state_next = S_RUN;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // active/fresh masks: end applied first, then start
    always_comb begin
        active_next = active_mask;
        fresh_next  = fresh_mask;
        if (state == S_RUN && end_program) begin
            active_next[programa] = 1'b0;
        end
        if (state == S_START_FRESH) begin
            fresh_next[programa] = 1'b0;
        end
        start_ok = start_program
                && (int'(start_slot) < NUM_PROGRAMS)
                && !active_next[start_slot];
        if (start_ok) begin
            active_next[start_slot] = 1'b1;
            fresh_next[start_slot]  = 1'b1;
        end
    end

    // sequencer state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // program slot bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_mask <= '0;
            fresh_mask  <= '0;
            programa    <= '0;
        end else begin
            active_mask <= active_next;
            fresh_mask  <= fresh_next;
            if (state == S_SELECT && sel_found) begin
                programa <= sel_slot;
            end
        end
    end

    // quantum counter: full reload on every RUN entry and on slice wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quantum_cnt <= QUANTUM_LOAD;
        end else if (state != S_RUN || state_next != S_RUN) begin
            quantum_cnt <= QUANTUM_LOAD;
        end else if (!cpu_stall) begin
            if (quantum_cnt == CNT_ONE) begin
                quantum_cnt <= QUANTUM_LOAD;
            end else begin
                quantum_cnt <= quantum_cnt - CNT_ONE;
            end
        end
    end

    // registered RAM strobes and fetch load pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spc           <= 1'b0;
            lpc           <= 1'b0;
            pc_load_en    <= 1'b0;
            enderecoSpc   <= '0;
            pc_load_value <= '0;
        end else begin
            spc        <= (state == S_RUN) && (state_next == S_SAVE);
            lpc        <= (state == S_SELECT) && (state_next == S_LOAD);
            pc_load_en <= (state == S_LOAD_WAIT)
                       || (state == S_START_FRESH);
            if (state == S_RUN && state_next == S_SAVE) begin
                enderecoSpc <= pc_atual;
            end
            if (state == S_LOAD_WAIT) begin
                pc_load_value <= ram_q;
            end else if (state == S_START_FRESH) begin
                pc_load_value <= '0;
            end
        end
    end

endmodule

// File: doc/escalonador_rr.md
Name: escalonador_rr

Overview:
- Round-robin program scheduler that time-slices the CPU between up to NUM_PROGRAMS programs.
- Each program owns a PARTITION_WORDS-word partition of the data RAM, and its saved PC lives at the partition base.
- The block tracks active programs and runs a quantum counter.
- It sequences the context switch on the data RAM: save the PC of the outgoing program (spc), select the next program, restore its PC (lpc) and hand it to the fetch stage. The CPU is held for the whole switch.

Parameters:
NUM_PROGRAMS, 4, number of program slots (slot index width SW = clog2(NUM_PROGRAMS))
QUANTUM, 16, CPU cycles per time slice
DATA_WIDTH, 32, PC / RAM data width

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high; clears all state
start_program  input  1  pulse: activate slot start_slot
start_slot  input  SW  slot to activate
end_program  input  1  pulse: running program halted
cpu_stall  input  1  CPU stalled this cycle; quantum does not count
pc_atual  input  DATA_WIDTH  current relative PC of running program
ram_q  input  DATA_WIDTH  data RAM read data (1-cycle read latency)
spc  output  1  data RAM: write enderecoSpc to base of partition programa
enderecoSpc  output  DATA_WIDTH  PC value to save
lpc  output  1  data RAM: read base of partition programa
programa  output  SW  slot currently owning CPU/RAM partition
pc_load_en  output  1  1-cycle pulse: fetch loads pc_load_value
pc_load_value  output  DATA_WIDTH  PC to load
cpu_hold  output  1  CPU must not advance
active_mask  output  NUM_PROGRAMS  bit i = slot i active
idle  output  1  no active program

Behaviour:
- Reset values:
  - state IDLE; programa=0; active_mask=0; fresh_mask=0; quantum counter=QUANTUM.
  - spc=lpc=pc_load_en=0; enderecoSpc=pc_load_value=0; cpu_hold=1; idle=1.
  - Reset mid-switch aborts the switch; no RAM strobe may appear after reset asserts.
- Registered outputs: spc, lpc, pc_load_en are single-cycle pulses; cpu_hold=1 in every state except RUN.
- States and transitions:
  - IDLE: idle=1. If active_mask!=0 -> SELECT.
  - RUN:
    - The counter decrements when !cpu_stall.
    - end_program: clear active bit of programa, no save -> SELECT. end_program wins over quantum expiry in the same cycle.
    - Counter at 1 with a decrement and another active slot exists -> SAVE.
    - Counter at 1 with only the running slot active: reload QUANTUM, stay in RUN, no switch.
  - SAVE (1 cycle): spc=1, enderecoSpc=pc_atual (sampled on RUN exit) -> SELECT.
  - SELECT (1 cycle):
    - programa = first active slot searching programa+1, programa+2, ... wrapping modulo NUM_PROGRAMS; the search includes programa itself last.
    - No active slot -> IDLE.
    - Selected slot fresh -> START_FRESH; otherwise -> LOAD.
  - LOAD (1 cycle): lpc=1 -> LOAD_WAIT.
  - LOAD_WAIT (1 cycle): pc_load_en=1, pc_load_value=ram_q -> RUN, counter=QUANTUM.
  - START_FRESH (1 cycle): pc_load_en=1, pc_load_value=0, clear fresh bit -> RUN, counter=QUANTUM.
- start_program is accepted in any state:
  - It sets active and fresh bits of start_slot.
  - It is ignored if start_slot is already active, including the running slot.
  - If the same cycle clears that slot via end_program, end is applied, then start is applied: the slot becomes active and fresh.
- Switch latency:
  - Quantum expiry to pc_load_en is 4 cycles (SAVE, SELECT, LOAD, LOAD_WAIT).
  - end_program to pc_load_en is 3 cycles, or 2 for a fresh target.
- idle = (active_mask==0), combinational from the registered mask.

Test Plan:
- Reset, start_program slot 2 -> SELECT then START_FRESH; pc_load_en with value 0 on the 3rd cycle after start; programa=2, cpu_hold drops.
- Slots 0 and 1 active, both not fresh, quantum 16, no stall -> after 16 RUN cycles: spc with enderecoSpc=pc_atual; lpc with programa=1; ram_q=0x2A drives pc_load_value=0x2A exactly 4 cycles after expiry.
- Single active slot, 40 cycles -> no spc/lpc; counter reloads every 16 cycles; cpu_hold stays 0.
- cpu_stall asserted for 5 cycles mid-slice -> switch occurs 21 cycles after RUN entry, not 16.
- Slots 1 and 3 active, programa=3, end_program coincident with expiry -> no spc, active_mask=0b0010, next programa=1 (wrap).
- Last active program ends -> idle=1, state IDLE; assert reset during LOAD -> lpc/pc_load_en never pulse afterwards, all outputs at reset values.
